// File: rtl/gpio_wr_arbiter.sv
// gpio_wr_arbiter: round-robin, lockable arbitration of masked requester and software writes to the GPIO OUT/OE registers
module gpio_wr_arbiter #(
  parameter int NumReq = 4,
  parameter int Width = 32,
  parameter int MaxLockCycles = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NumReq-1:0]          req_i,
  input  logic [NumReq-1:0]          sel_oe_i,
  input  logic [NumReq-1:0]          lock_i,
  input  logic [NumReq*Width-1:0]    data_i,
  input  logic [NumReq*Width-1:0]    mask_i,
  output logic [NumReq-1:0]          gnt_o,
  input  logic                       sw_we_i,
  input  logic                       sw_sel_oe_i,
  input  logic [Width-1:0]           sw_data_i,
  output logic [Width-1:0]           cio_gpio_o,
  output logic [Width-1:0]           cio_gpio_en_o,
  output logic                       locked_o,
  output logic [$clog2(NumReq)-1:0]  owner_o,
  output logic                       lock_err_o
);
  localparam int OW = $clog2(NumReq);
  localparam int CW = $clog2(MaxLockCycles);
  typedef enum logic {IDLE, LOCKED} state_e;
  state_e state_q, state_d;
  logic [OW-1:0] p_q, p_d, owner_d, idx, pick;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [Width-1:0] out_d, oe_d, wr_val;
  logic [Width-1:0] dat [NumReq];
  logic [Width-1:0] msk [NumReq];
  logic hit, g, expire;
  for (genvar k = 0; k < NumReq; k++) begin : g_unpack
    assign dat[k] = data_i[k*Width +: Width];
    assign msk[k] = mask_i[k*Width +: Width];
  end
  // Descending scan so the requester closest to the rr pointer is the last one kept
  always_comb begin
    pick = owner_o;
    hit = req_i[owner_o];
    idx = '0;
    if (state_q == IDLE) begin
      hit = 1'b0;
      for (int i = NumReq - 1; i >= 0; i--) begin
        idx = OW'((int'(p_q) + i) % NumReq);
        if (req_i[idx]) begin
          pick = idx;
          hit = 1'b1;
        end
      end
    end
    g = hit && !sw_we_i && !rst_i;
    gnt_o = '0;
    gnt_o[pick] = g;
    wr_val = (msk[pick] & dat[pick]) | (~msk[pick] & (sel_oe_i[pick] ? cio_gpio_en_o : cio_gpio_o));
    expire = state_q == LOCKED && !sw_we_i && cnt_q == CW'(MaxLockCycles - 1);
    out_d = (sw_we_i && !sw_sel_oe_i) ? sw_data_i : (g && !sel_oe_i[pick]) ? wr_val : cio_gpio_o;
    oe_d = (sw_we_i && sw_sel_oe_i) ? sw_data_i : (g && sel_oe_i[pick]) ? wr_val : cio_gpio_en_o;
    state_d = state_q;
    p_d = p_q;
    owner_d = owner_o;
    cnt_d = cnt_q;
    if (!sw_we_i && state_q == LOCKED) begin
      cnt_d = cnt_q + 1'b1;
      if (!lock_i[owner_o] || expire) state_d = IDLE;
    end else if (g) begin
      p_d = (pick == OW'(NumReq - 1)) ? '0 : pick + 1'b1;
      owner_d = pick;
      if (lock_i[pick]) begin
        state_d = LOCKED;
        cnt_d = '0;
      end
    end
  end
  assign locked_o = state_q == LOCKED;
  assign lock_err_o = expire;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      p_q <= '0;
      owner_o <= '0;
      cnt_q <= '0;
      cio_gpio_o <= '0;
      cio_gpio_en_o <= '0;
    end else begin
      state_q <= state_d;
      p_q <= p_d;
      owner_o <= owner_d;
      cnt_q <= cnt_d;
      cio_gpio_o <= out_d;
      cio_gpio_en_o <= oe_d;
    end
  end
endmodule

// File: tb/tb_gpio_wr_arbiter.sv
// tb_gpio_wr_arbiter: directed and randomized checks of gpio_wr_arbiter against a behavioural model
module tb_gpio_wr_arbiter;
  localparam int N = 4;
  localparam int W = 32;
  localparam int ML = 64;
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  logic [N-1:0] req_i = '0, sel_oe_i = '0, lock_i = '0, gnt_o;
  logic [W-1:0] dat [N];
  logic [W-1:0] msk [N];
  logic [N*W-1:0] data_i, mask_i;
  logic sw_we_i = 1'b0, sw_sel_oe_i = 1'b0;
  logic [W-1:0] sw_data_i = '0;
  logic [W-1:0] cio_gpio_o, cio_gpio_en_o;
  logic locked_o, lock_err_o;
  logic [1:0] owner_o;
  logic [W-1:0] m_out, m_oe, m_val, eg;
  int m_p, m_owner, m_age, e_idx, err_at;
  bit m_locked, e_err;
  int total = 0;
  int bad = 0;
  assign data_i = {dat[3], dat[2], dat[1], dat[0]};
  assign mask_i = {msk[3], msk[2], msk[1], msk[0]};
  always #5 clk_i = ~clk_i;
  gpio_wr_arbiter #(.NumReq(N), .Width(W), .MaxLockCycles(ML)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .sel_oe_i(sel_oe_i), .lock_i(lock_i),
    .data_i(data_i), .mask_i(mask_i), .gnt_o(gnt_o), .sw_we_i(sw_we_i),
    .sw_sel_oe_i(sw_sel_oe_i), .sw_data_i(sw_data_i), .cio_gpio_o(cio_gpio_o),
    .cio_gpio_en_o(cio_gpio_en_o), .locked_o(locked_o), .owner_o(owner_o), .lock_err_o(lock_err_o)
  );
  task automatic chk(string n, logic [W-1:0] a, logic [W-1:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", n, a, e, $time);
    end
  endtask
  task automatic model_reset();
    m_out = '0;
    m_oe = '0;
    m_p = 0;
    m_owner = 0;
    m_age = 0;
    m_locked = 0;
  endtask
  // Which requester may write this cycle, and whether the lock has run out of time
  function automatic void model_comb();
    e_idx = -1;
    e_err = 0;
    if (!sw_we_i) begin
      if (m_locked) begin
        if (req_i[m_owner]) e_idx = m_owner;
        e_err = (m_age == ML - 1);
      end else begin
        for (int i = 0; i < N; i++)
          if (e_idx < 0 && req_i[(m_p + i) % N]) e_idx = (m_p + i) % N;
      end
    end
    eg = (e_idx < 0) ? '0 : (32'd1 << e_idx);
  endfunction
  task automatic model_seq();
    if (sw_we_i) begin
      if (sw_sel_oe_i) m_oe = sw_data_i;
      else m_out = sw_data_i;
    end else begin
      if (e_idx >= 0) begin
        m_val = sel_oe_i[e_idx] ? m_oe : m_out;
        m_val = (msk[e_idx] & dat[e_idx]) | (~msk[e_idx] & m_val);
        if (sel_oe_i[e_idx]) m_oe = m_val;
        else m_out = m_val;
      end
      if (m_locked) begin
        m_age++;
        if (!lock_i[m_owner] || e_err) m_locked = 0;
      end else if (e_idx >= 0) begin
        m_p = (e_idx + 1) % N;
        m_owner = e_idx;
        if (lock_i[e_idx]) begin
          m_locked = 1;
          m_age = 0;
        end
      end
    end
  endtask
  task automatic cyc();
    #1;
    model_comb();
    chk("gnt", W'(gnt_o), eg);
    chk("lock_err", W'(lock_err_o), W'(e_err));
    chk("out", cio_gpio_o, m_out);
    chk("oe", cio_gpio_en_o, m_oe);
    chk("locked", W'(locked_o), W'(m_locked));
    chk("owner", W'(owner_o), W'(m_owner));
    @(posedge clk_i);
    model_seq();
    @(negedge clk_i);
  endtask
  task automatic do_reset();
    rst_i = 1'b1;
    #1;
    chk("rst_out", cio_gpio_o, '0);
    chk("rst_oe", cio_gpio_en_o, '0);
    chk("rst_locked", W'(locked_o), '0);
    chk("rst_gnt", W'(gnt_o), '0);
    chk("rst_owner", W'(owner_o), '0);
    chk("rst_err", W'(lock_err_o), '0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    model_reset();
  endtask
  initial begin
    for (int k = 0; k < N; k++) begin
      dat[k] = '0;
      msk[k] = '0;
    end
    model_reset();
    #1;
    do_reset();
    req_i = 4'b0001;
    dat[0] = 32'hFFFF_0000;
    msk[0] = 32'h00FF_FF00;
    #1 chk("t1_gnt", W'(gnt_o), 32'd1);
    cyc();
    chk("t1_out", cio_gpio_o, 32'h00FF_0000);
    chk("t1_oe", cio_gpio_en_o, '0);
    req_i = '0;
    do_reset();
    req_i = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < N; k++) begin
        dat[k] = $urandom;
        msk[k] = $urandom;
      end
      sel_oe_i = N'($urandom);
      #1 chk("t2_gnt", W'(gnt_o), 32'd1 << (i % 4));
      cyc();
      chk("t2_owner", W'(owner_o), W'(i % 4));
    end
    req_i = 4'b0100;
    lock_i = 4'b0100;
    #1 chk("t3_gnt2", W'(gnt_o), 32'd4);
    cyc();
    chk("t3_locked", W'(locked_o), 32'd1);
    req_i = 4'b0101;
    repeat (3) begin
      #1 chk("t3_hold", W'(gnt_o), 32'd4);
      cyc();
    end
    lock_i = '0;
    req_i = 4'b0001;
    #1 chk("t3_blocked", W'(gnt_o), '0);
    cyc();
    chk("t3_unlocked", W'(locked_o), '0);
    #1 chk("t3_req0", W'(gnt_o), 32'd1);
    cyc();
    req_i = 4'b0010;
    lock_i = 4'b0010;
    cyc();
    req_i = 4'b1111;
    err_at = -1;
    for (int j = 0; j < 100 && err_at < 0; j++) begin
      #1 if (lock_err_o) err_at = j;
      cyc();
    end
    chk("t4_err_at", W'(err_at), 32'd63);
    chk("t4_unlocked", W'(locked_o), '0);
    chk("t4_err_once", W'(lock_err_o), '0);
    req_i = 4'b1101;
    #1 chk("t4_next", W'(gnt_o), 32'd4);
    cyc();
    req_i = 4'b0010;
    lock_i = '0;
    sw_we_i = 1'b1;
    sw_sel_oe_i = 1'b1;
    sw_data_i = 32'h1234_5678;
    #1 chk("t5_sw_gnt", W'(gnt_o), '0);
    cyc();
    sw_we_i = 1'b0;
    chk("t5_oe", cio_gpio_en_o, 32'h1234_5678);
    #1 chk("t5_req1", W'(gnt_o), 32'd2);
    cyc();
    req_i = '0;
    sw_we_i = 1'b1;
    sw_sel_oe_i = 1'b0;
    sw_data_i = 32'hDEAD_BEEF;
    cyc();
    sw_we_i = 1'b0;
    msk[3] = '0;
    req_i = 4'b1000;
    lock_i = 4'b1000;
    cyc();
    chk("t6_locked", W'(locked_o), 32'd1);
    chk("t6_out", cio_gpio_o, 32'hDEAD_BEEF);
    #2 rst_i = 1'b1;
    #1;
    chk("t6_async_out", cio_gpio_o, '0);
    chk("t6_async_locked", W'(locked_o), '0);
    chk("t6_async_gnt", W'(gnt_o), '0);
    @(negedge clk_i);
    rst_i = 1'b0;
    model_reset();
    for (int c = 0; c < 3600; c++) begin
      for (int k = 0; k < N; k++) begin
        dat[k] = $urandom;
        msk[k] = $urandom;
        req_i[k] = $urandom_range(0, 3) != 0;
        lock_i[k] = ((c / 400) % 3 == 0) ? ($urandom_range(0, 3) == 0) :
                    ((c / 400) % 3 == 1) ? ($urandom_range(0, 15) != 0) : 1'b1;
      end
      sel_oe_i = N'($urandom);
      sw_we_i = $urandom_range(0, 9) == 0;
      sw_sel_oe_i = 1'($urandom);
      sw_data_i = $urandom;
      cyc();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gpio_wr_arbiter.md
Name: gpio_wr_arbiter

Overview:
Shares the GPIO output-value and output-enable registers between NumReq hardware requesters and one software write port. Each requester issues masked writes (data + mask, targeting OUT or OE) through a req/gnt handshake, and a round-robin arbiter grants one requester per cycle. An optional lock gives a requester atomic multi-write ownership, bounded by a timeout. The block owns the output/OE state and drives the pad-side cio outputs directly.

Parameters:
NumReq, 4, number of hardware requesters (2..8)
Width, 32, GPIO bit count
MaxLockCycles, 64, maximum consecutive cycles in LOCKED before forced release (>=2)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
req_i  in  NumReq  per-requester write request; held until granted
sel_oe_i  in  NumReq  per-requester target: 0 = OUT, 1 = OE
lock_i  in  NumReq  per-requester request to retain ownership after grant
data_i  in  NumReq*Width  per-requester write data, requester k at [k*Width +: Width]
mask_i  in  NumReq*Width  per-requester bit mask, same packing as data_i
gnt_o  out  NumReq  one-hot grant, combinational, at most one bit set
sw_we_i  in  1  software write strobe, single cycle
sw_sel_oe_i  in  1  software target: 0 = OUT, 1 = OE
sw_data_i  in  Width  software write data (full-width, mask all ones)
cio_gpio_o  out  Width  output value register
cio_gpio_en_o  out  Width  output-enable register
locked_o  out  1  FSM in LOCKED
owner_o  out  clog2(NumReq)  index of the last granted requester
lock_err_o  out  1  one-cycle pulse on lock timeout

Behaviour:
- Reset (async, rst_i=1) sets cio_gpio_o, cio_gpio_en_o, owner_o, rr pointer, lock counter, locked_o and lock_err_o to 0, and the FSM to IDLE. gnt_o is 0 while rst_i=1.
- Write rule, for the selected target register R: R <= (mask & data) | (~mask & R). The update is visible on outputs at the clock edge ending the grant cycle (latency 1). Software writes use mask = all ones.
- Software priority: in any cycle with sw_we_i=1, gnt_o=0 and only the software write is applied. Pending requests stay pending. The rr pointer, the lock counter and the FSM state are unchanged, so the counter freezes.
- FSM IDLE:
  - Grant the first requester with req_i=1, scanning from rr pointer p upward and wrapping modulo NumReq. On grant to k: p <= (k+1) mod NumReq, owner_o <= k.
  - If lock_i[k]=1 in the grant cycle, go to LOCKED and clear the counter.
  - No requests: gnt_o=0 and p is held.
- FSM LOCKED:
  - Only requester owner_o can be granted; all other requests are blocked.
  - Owner with req_i=1 is granted every cycle. The write is applied as in IDLE.
  - Exit to IDLE at the end of the first cycle in which the owner's lock_i=0, whether or not a grant occurs that cycle. p is not advanced on the exit itself.
  - The counter increments every non-sw cycle in LOCKED. When it reaches MaxLockCycles-1 while still LOCKED: pulse lock_err_o for 1 cycle and force IDLE. The owner's grant in that cycle, if any, still completes.
- Handshake: gnt_o[k] asserts only when req_i[k]=1. data/mask/sel_oe are sampled in the grant cycle. A requester deasserting req without a grant is legal; no write occurs.
- Simultaneous events:
  - Software write and lock expiry in the same cycle: software wins and the counter holds, so expiry is deferred.
  - Reset mid-LOCKED drops ownership immediately.
- owner_o is meaningful only after a first grant. Out-of-range owner is impossible by construction.

Test Plan:
1. Reset, then req_i=4'b0001, sel_oe=0, data=32'hFFFF_0000, mask=32'h00FF_FF00 -> gnt_o=0001 that cycle; next cycle cio_gpio_o=32'h00FF_0000, cio_gpio_en_o=0.
2. req_i=4'b1111 held for 8 cycles with lock_i=0 -> grant order 0,1,2,3,0,1,2,3; owner_o follows the same order.
3. Requester 2 granted with lock_i[2]=1, while req_i[0] stays asserted -> locked_o=1; req0 not granted until lock_i[2]=0; req0 granted in the cycle after locked_o falls.
4. Requester 1 holds lock_i=1 for 100 cycles with MaxLockCycles=64 -> lock_err_o pulses exactly once, 63 cycles after lock entry; locked_o=0 next cycle; other requesters granted afterward.
5. sw_we_i=1 with sw_data_i=32'h1234_5678 and sw_sel_oe=1 in the same cycle as req_i=4'b0010 -> gnt_o=0; cio_gpio_en_o=32'h1234_5678 next cycle; req1 granted the following cycle.
6. Assert rst_i while LOCKED with cio_gpio_o=32'hDEAD_BEEF -> cio_gpio_o=0, locked_o=0 and gnt_o=0 immediately (asynchronous), before any clock edge.
